// File: rtl/decode_stage.sv
// Instruction-decode stage of the 16-bit pipelined MIPS: register file with write-through
// bypass, control decode, load-use hazard detection and the ID/EX pipeline register.
module decode_stage #(
  parameter int unsigned NREGS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] if_id_instr,
  input  logic [15:0] if_id_pc_plus_2,
  input  logic        wb_reg_write,
  input  logic [2:0]  wb_write_reg,
  input  logic [15:0] wb_write_data,
  input  logic        flush,
  output logic        stall,
  output logic [15:0] pc_plus_2_out_pipe_2,
  output logic [15:0] read_data_1_out_pipe_2,
  output logic [15:0] read_data_2_out_pipe_2,
  output logic [15:0] sign_extended_imm_out_pipe_2,
  output logic [2:0]  rs_pipe_2,
  output logic [2:0]  rt_pipe_2,
  output logic [2:0]  rd_pipe_2,
  output logic        aluSrc,
  output logic        regDst,
  output logic        memRead,
  output logic        memWrite,
  output logic        memToReg,
  output logic        regWrite,
  output logic        branch,
  output logic [1:0]  aluOp
);

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;

  typedef struct packed {
    logic       alu_src;
    logic       reg_dst;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  logic [RW-1:0] opcode, rs, rt, rd;
  logic [DW-1:0] imm_ext;
  logic [DW-1:0] rdata1, rdata2;
  ctrl_t         ctrl_dec;
  logic          rs_used, rt_used;

  logic [DW-1:0] regs_q [NREGS];

  logic [DW-1:0] pc_q, rd1_q, rd2_q, imm_q;
  logic [RW-1:0] rs_q, rt_q, rd_q;
  ctrl_t         ctrl_q, ctrl_d;

  assign opcode  = if_id_instr[15:13];
  assign rs      = if_id_instr[12:10];
  assign rt      = if_id_instr[9:7];
  assign rd      = if_id_instr[6:4];
  assign imm_ext = {{9{if_id_instr[6]}}, if_id_instr[6:0]};

  // Register file; r0 is never written and always reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (wb_reg_write && (wb_write_reg != RW'(0))) begin
      regs_q[wb_write_reg] <= wb_write_data;
    end
  end

  // Write-through read ports so a same-cycle writeback is visible to decode.
  always_comb begin
    rdata1 = '0;
    if (rs != RW'(0)) begin
      rdata1 = (wb_reg_write && (wb_write_reg == rs)) ? wb_write_data : regs_q[rs];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rt != RW'(0)) begin
      rdata2 = (wb_reg_write && (wb_write_reg == rt)) ? wb_write_data : regs_q[rt];
    end
  end

  always_comb begin
    ctrl_dec = '0;
    rs_used  = 1'b0;
    rt_used  = 1'b0;
    unique case (opcode)
      3'b000: begin
        ctrl_dec.reg_dst   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = 2'b10;
        rs_used            = 1'b1;
        rt_used            = 1'b1;
      end
      3'b001: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        rs_used            = 1'b1;
      end
      3'b010: begin
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
        rs_used             = 1'b1;
      end
      3'b011: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.mem_write = 1'b1;
        rs_used            = 1'b1;
        rt_used            = 1'b1;
      end
      3'b100: begin
        ctrl_dec.branch = 1'b1;
        ctrl_dec.alu_op = 2'b01;
        rs_used         = 1'b1;
        rt_used         = 1'b1;
      end
      default: ctrl_dec = '0;
    endcase
  end

  // Load-use: the load in ID/EX targets a register the decoding instruction reads.
  assign stall = ctrl_q.mem_read && (rt_q != RW'(0)) &&
                 ((rs_used && (rt_q == rs)) || (rt_used && (rt_q == rt)));

  always_comb begin
    ctrl_d = ctrl_dec;
    if (flush || stall) ctrl_d = '0;
  end

  // ID/EX register; a bubble only zeroes the controls, data still loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      ctrl_q <= '0;
    end else begin
      pc_q   <= if_id_pc_plus_2;
      rd1_q  <= rdata1;
      rd2_q  <= rdata2;
      imm_q  <= imm_ext;
      rs_q   <= rs;
      rt_q   <= rt;
      rd_q   <= rd;
      ctrl_q <= ctrl_d;
    end
  end

  assign pc_plus_2_out_pipe_2         = pc_q;
  assign read_data_1_out_pipe_2       = rd1_q;
  assign read_data_2_out_pipe_2       = rd2_q;
  assign sign_extended_imm_out_pipe_2 = imm_q;
  assign rs_pipe_2                    = rs_q;
  assign rt_pipe_2                    = rt_q;
  assign rd_pipe_2                    = rd_q;
  assign aluSrc                       = ctrl_q.alu_src;
  assign regDst                       = ctrl_q.reg_dst;
  assign memRead                      = ctrl_q.mem_read;
  assign memWrite                     = ctrl_q.mem_write;
  assign memToReg                     = ctrl_q.mem_to_reg;
  assign regWrite                     = ctrl_q.reg_write;
  assign branch                       = ctrl_q.branch;
  assign aluOp                        = ctrl_q.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a driver predicts each ID/EX load from a register-array
// model and queues it; a monitor pops and compares after every clock edge.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] if_id_instr = '0;
  logic [15:0] if_id_pc_plus_2 = '0;
  logic        wb_reg_write = 1'b0;
  logic [2:0]  wb_write_reg = '0;
  logic [15:0] wb_write_data = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic [15:0] pc_o, rd1_o, rd2_o, imm_o;
  logic [2:0]  rs_o, rt_o, rd_o;
  logic        alu_src, reg_dst, mem_read, mem_write, mem_to_reg, reg_write, br;
  logic [1:0]  alu_op;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .if_id_instr(if_id_instr), .if_id_pc_plus_2(if_id_pc_plus_2),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .flush(flush), .stall(stall), .pc_plus_2_out_pipe_2(pc_o), .read_data_1_out_pipe_2(rd1_o),
    .read_data_2_out_pipe_2(rd2_o), .sign_extended_imm_out_pipe_2(imm_o), .rs_pipe_2(rs_o),
    .rt_pipe_2(rt_o), .rd_pipe_2(rd_o), .aluSrc(alu_src), .regDst(reg_dst), .memRead(mem_read),
    .memWrite(mem_write), .memToReg(mem_to_reg), .regWrite(reg_write), .branch(br), .aluOp(alu_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        bubble;
    logic [81:0] v;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] mregs [8];
  logic        m_load_in_ex;
  logic [2:0]  m_load_rt;

  function automatic logic [81:0] observed();
    return {pc_o, rd1_o, rd2_o, imm_o, rs_o, rt_o, rd_o,
            alu_src, reg_dst, mem_read, mem_write, mem_to_reg, reg_write, br, alu_op};
  endfunction

  // Control word {aluSrc,regDst,memRead,memWrite,memToReg,regWrite,branch,aluOp}.
  function automatic logic [8:0] table_ctrl(input int opc);
    case (opc)
      0: return 9'b0_1_0_0_0_1_0_10;
      1: return 9'b1_0_0_0_0_1_0_00;
      2: return 9'b1_0_1_0_1_1_0_00;
      3: return 9'b1_0_0_1_0_0_0_00;
      4: return 9'b0_0_0_0_0_0_1_01;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [15:0] model_read(input int idx);
    if (idx == 0) return 16'h0;
    if (wb_reg_write && int'(wb_write_reg) == idx) return wb_write_data;
    return mregs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    m_load_in_ex = 1'b0;
    m_load_rt    = 3'd0;
  endtask

  // One decode cycle: drive, check stall, predict ID/EX, advance the model.
  task automatic step(input logic [15:0] instr, input logic fl, input logic we,
                      input logic [2:0] wr, input logic [15:0] wd, output logic held);
    int   opc, rs, rt, rd;
    logic exp_stall;
    exp_t e;
    @(negedge clk);
    if_id_instr     = instr;
    if_id_pc_plus_2 = 16'($urandom);
    flush           = fl;
    wb_reg_write    = we;
    wb_write_reg    = wr;
    wb_write_data   = wd;
    #1;
    opc = int'(instr[15:13]);
    rs  = int'(instr[12:10]);
    rt  = int'(instr[9:7]);
    rd  = int'(instr[6:4]);
    exp_stall = m_load_in_ex && m_load_rt != 3'd0 &&
                ((opc <= 4 && int'(m_load_rt) == rs) ||
                 ((opc == 0 || opc == 3 || opc == 4) && int'(m_load_rt) == rt));
    total++;
    if (stall !== exp_stall) begin
      bad++;
      $display("FAIL stall instr=%h got=%b exp=%b t=%0t", instr, stall, exp_stall, $time);
    end
    e.bubble = fl || exp_stall;
    e.v = {if_id_pc_plus_2, model_read(rs), model_read(rt),
           {{9{instr[6]}}, instr[6:0]}, 3'(rs), 3'(rt), 3'(rd),
           e.bubble ? 9'b0 : table_ctrl(opc)};
    sbq.push_back(e);
    if (we && wr != 3'd0) mregs[wr] = wd;
    m_load_in_ex = !e.bubble && opc == 2;
    m_load_rt    = 3'(rt);
    held = exp_stall && !fl;
  endtask

  task automatic issue(input logic [15:0] instr, input logic fl);
    logic held;
    int   n = 0;
    step(instr, fl, 1'b0, 3'd0, 16'h0, held);
    while (held && n < 4) begin
      step(instr, 1'b0, 1'b0, 3'd0, 16'h0, held);
      n++;
    end
    total++;
    if (held) begin
      bad++;
      $display("FAIL stall_stuck instr=%h got=held exp=released", instr);
    end
  endtask

  task automatic check_reset_state(input string name);
    total++;
    if (observed() !== 82'h0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL %s got=%h stall=%b exp=0", name, observed(), stall);
    end
  endtask

  // Monitor: every edge with a pending prediction presents a new ID/EX value.
  initial begin
    exp_t       e;
    logic [81:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e   = sbq.pop_front();
        got = observed();
        total++;
        if (e.bubble ? (got[8:0] !== e.v[8:0]) : (got !== e.v)) begin
          bad++;
          $display("FAIL idex bubble=%b got=%h exp=%h t=%0t", e.bubble, got, e.v, $time);
        end
      end
    end
  end

  initial begin
    logic        held;
    logic [15:0] cur;
    int          waitc;
    model_reset();
    #2;
    check_reset_state("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Writeback with same-cycle bypass into an R-type read.
    step({3'b000, 3'd3, 3'd0, 3'd5, 4'h2}, 1'b0, 1'b1, 3'd3, 16'h1234, held);
    // addi with all-ones immediate from r0, then a write aimed at r0.
    issue({3'b001, 3'd0, 3'd1, 7'h7F}, 1'b0);
    step({3'b000, 3'd0, 3'd0, 3'd1, 4'h0}, 1'b0, 1'b1, 3'd0, 16'hBEEF, held);
    issue({3'b000, 3'd0, 3'd3, 3'd1, 4'h0}, 1'b0);
    // Load-use on rs, then lw followed by addi whose rt is only a destination.
    step({3'b010, 3'd3, 3'd2, 7'd4}, 1'b0, 1'b1, 3'd2, 16'h00AA, held);
    issue({3'b000, 3'd2, 3'd3, 3'd4, 4'h0}, 1'b0);
    issue({3'b010, 3'd3, 3'd2, 7'd4}, 1'b0);
    issue({3'b001, 3'd1, 3'd2, 7'h05}, 1'b0);
    // Flush of a beq, then flush coinciding with a load-use stall.
    issue({3'b100, 3'd1, 3'd2, 7'h03}, 1'b1);
    issue({3'b010, 3'd0, 3'd3, 7'd0}, 1'b0);
    step({3'b011, 3'd3, 3'd1, 7'h01}, 1'b1, 1'b0, 3'd0, 16'h0, held);

    // Asynchronous reset mid-cycle with a live instruction present.
    @(negedge clk);
    if_id_instr = 16'h4A85;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_state("reset_async");
    @(negedge clk);
    if_id_instr = 16'h0000;
    rst_n = 1'b1;
    for (int i = 1; i < 8; i++) issue({3'b000, 3'(i), 3'(i), 3'd1, 4'h0}, 1'b0);

    // Randomized stream; a stalled instruction is held in IF/ID unless flushed.
    cur = 16'($urandom);
    for (int c = 0; c < 3000; c++) begin
      step(cur, ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
           3'($urandom), 16'($urandom), held);
      if (!held) cur = 16'($urandom);
    end

    waitc = 0;
    while (sbq.size() > 0 && waitc < 10) begin
      @(posedge clk);
      waitc++;
    end
    #2;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending exp=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the 16-bit pipelined MIPS, directly upstream of the execute stage. It holds the 8×16 register file with write-through bypass and decodes the IF/ID instruction into control signals. It also detects load-use hazards and registers everything into the ID/EX pipeline register that the execute stage consumes. Writeback enters through a dedicated write port; stall and flush handling live here.

## Interface
Parameters:
- `NREGS`, default 8: register count; fixed by the 3-bit register fields.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_id_instr` in 16: instruction from IF/ID.
  - `[15:13]` opcode, `[12:10]` rs, `[9:7]` rt, `[6:4]` rd, `[3:0]` func.
  - `[6:0]` is the I-type immediate.
- `if_id_pc_plus_2` in 16: PC+2 from IF/ID.
- `wb_reg_write` in 1: writeback enable.
- `wb_write_reg` in 3: writeback destination.
- `wb_write_data` in 16: writeback data.
- `flush` in 1: branch taken; squash the instruction currently in decode.
- `stall` out 1: combinational; holds PC and IF/ID when high.
- `pc_plus_2_out_pipe_2` out 16: registered PC+2.
- `read_data_1_out_pipe_2` out 16: registered rs data.
- `read_data_2_out_pipe_2` out 16: registered rt data.
- `sign_extended_imm_out_pipe_2` out 16: registered sign-extended `instr[6:0]`.
- `rs_pipe_2` out 3: registered rs field.
- `rt_pipe_2` out 3: registered rt field.
- `rd_pipe_2` out 3: registered rd field.
- `aluSrc`, `regDst`, `memRead`, `memWrite`, `memToReg`, `regWrite`, `branch` out 1 each: registered controls.
- `aluOp` out 2: registered control.

## Operation
Decode table (opcode → controls); any control not listed is 0:
- 000 R-type: `regDst`=1, `regWrite`=1, `aluOp`=10.
- 001 addi: `aluSrc`=1, `regWrite`=1, `aluOp`=00.
- 010 lw: `aluSrc`=1, `memRead`=1, `memToReg`=1, `regWrite`=1, `aluOp`=00.
- 011 sw: `aluSrc`=1, `memWrite`=1, `aluOp`=00.
- 100 beq: `branch`=1, `aluOp`=01.
- 101–111: all controls 0 (nop).

Register file:
- r0 reads 0 always; writes to r0 are ignored.
- Write occurs on the rising edge when `wb_reg_write`=1.
- Read is combinational with write-through: if `wb_reg_write` is high and `wb_write_reg` equals the read index (≠0), the read returns `wb_write_data` in the same cycle.

Immediate: `{{9{instr[6]}}, instr[6:0]}`. Func therefore appears as `imm[3:0]`.

Hazard detection (load-use):
- `stall` = `memRead` (ID/EX) && `rt_pipe_2`≠0 && (`rt_pipe_2`==rs || (`rt_pipe_2`==rt && opcode ∈ {000, 011, 100})).
- rs counts as a source for every opcode except 101–111.

ID/EX update on each rising edge, highest priority first:
- If `flush` or `stall`: load a bubble.
  - All control outputs go to 0.
  - Data and field outputs load normally; their values are don't-care but must be deterministic.
- Otherwise: load the decoded controls, register data, immediate, fields and PC+2.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - All ID/EX outputs go to 0 immediately.
  - All 8 registers clear to 0.
  - `stall` therefore goes to 0.
- Latency: an instruction on `if_id_instr` in cycle N appears on ID/EX outputs after edge N+1.
- `stall` is asserted for exactly one cycle per load-use pair. The bubble clears `memRead` in ID/EX, so `stall` drops in the next cycle while the same instruction is still held in IF/ID.
- `flush` and `stall` together: a bubble is inserted and `stall` is still driven. The fetch stage gives `flush` priority.
- Write and read of the same register in the same cycle: the bypassed value is captured into ID/EX.
- Reset released mid-stream: the first edge after release loads whatever is in IF/ID (0x0000, an R-type with all-zero fields, writes r0 → harmless).

## Test plan
1. Reset:
   - Stimulus: hold `rst_n`=0 mid-cycle with a live instruction present.
   - Expected: all outputs 0 immediately; after release, reads of r1–r7 return 0.
2. Writeback then read with bypass:
   - Stimulus: write r3=0x1234; in the same cycle, decode R-type with rs=3, rt=0, rd=5, func=0x2.
   - Expected: next edge gives `read_data_1`=0x1234, `read_data_2`=0, `regDst`=1, `aluOp`=10, `rd_pipe_2`=5, `sign_extended_imm[3:0]`=0x2.
3. Immediate and r0:
   - Stimulus: addi with `imm`=0x7F, rs=0.
   - Expected: `sign_extended_imm`=0xFFFF, `aluSrc`=1, `read_data_1`=0.
   - Stimulus: write to r0 with data 0xBEEF.
   - Expected: r0 still reads 0.
4. Load-use:
   - Stimulus: lw rt=2, followed by R-type with rs=2.
   - Expected: `stall`=1 for one cycle; ID/EX controls all 0 on the next edge; the R-type issues one cycle later.
   - Stimulus: lw rt=2, followed by addi with rt=2.
   - Expected: no stall.
5. Flush:
   - Stimulus: `flush`=1 while beq is in decode.
   - Expected: next edge gives `branch`=0 and `regWrite`=0.
   - Stimulus: `flush` and `stall` together.
   - Expected: bubble inserted and `stall`=1.
